// File: rtl/wave_pkg.sv
// Shared definitions for the waveform sequencing blocks: mode codes,
// per-mode period lengths in clock cycles, and the scheduler state type.
package wave_pkg;

  localparam logic [1:0] MODE_SQR  = 2'd0;
  localparam logic [1:0] MODE_SAW  = 2'd1;
  localparam logic [1:0] MODE_TRI  = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  localparam logic [5:0] LEN_SQR  = 6'd20;
  localparam logic [5:0] LEN_SAW  = 6'd21;
  localparam logic [5:0] LEN_TRI  = 6'd40;
  localparam logic [5:0] LEN_HOLD = 6'd1;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [5:0] period_len(input logic [1:0] mode);
    case (mode)
      MODE_SQR: return LEN_SQR;
      MODE_SAW: return LEN_SAW;
      MODE_TRI: return LEN_TRI;
      default:  return LEN_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that was not served
// last wins; a lone valid requester always wins.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last_id,
  output logic       grant,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req_valid;
    if (&req_valid)
      grant = ~last_id;
    else
      grant = req_valid[1];
  end

endmodule

// File: rtl/wave_scheduler.sv
// Grants generator jobs to two requesters round-robin, holds the chosen mode
// for a whole number of periods, then parks the generator in hold mode.
module wave_scheduler
  import wave_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0][1:0]     req_mode,
  input  logic [NREQ-1:0][PW-1:0]  req_periods,
  input  logic                     abort,
  output logic [1:0]               wave_choise,
  output logic                     busy,
  output logic                     cur_id,
  output logic                     done,
  output logic                     done_id,
  output logic                     done_aborted
);

  state_t        state;
  logic          last_id;
  logic [PW-1:0] periods_reg;
  logic [5:0]    cyc_cnt;
  logic [PW-1:0] per_cnt;
  logic          grant;
  logic          grant_valid;
  logic          accept;
  logic [5:0]    len;
  logic [PW-1:0] last_per_idx;
  logic          last_cyc;
  logic          complete;

  rr_arb2 u_arb (
    .req_valid   (req_valid),
    .last_id     (last_id),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = (state == IDLE) && req_valid[gi] && (grant == 1'(gi));
  end

  assign accept = (state == IDLE) && grant_valid;

  // In RUN the registered wave_choise already holds the latched mode.
  assign len          = period_len(wave_choise);
  assign last_per_idx = periods_reg - 1'b1;  // 0 wraps to all-ones, i.e. 2^PW periods
  assign last_cyc     = (cyc_cnt == len - 6'd1);
  assign complete     = last_cyc && (per_cnt == last_per_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_id      <= 1'b1;
      periods_reg  <= '0;
      cyc_cnt      <= '0;
      per_cnt      <= '0;
      wave_choise  <= MODE_HOLD;
      busy         <= 1'b0;
      cur_id       <= 1'b0;
      done         <= 1'b0;
      done_id      <= 1'b0;
      done_aborted <= 1'b0;
    end else begin
      done         <= 1'b0;
      done_aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= RUN;
            periods_reg <= req_periods[grant];
            wave_choise <= req_mode[grant];
            cur_id      <= grant;
            last_id     <= grant;
            cyc_cnt     <= '0;
            per_cnt     <= '0;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          // Abort takes priority over a coinciding natural completion.
          if (abort || complete) begin
            state        <= IDLE;
            wave_choise  <= MODE_HOLD;
            busy         <= 1'b0;
            done         <= 1'b1;
            done_id      <= cur_id;
            done_aborted <= abort;
          end else if (last_cyc) begin
            cyc_cnt <= '0;
            per_cnt <= per_cnt + 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 6'd1;
          end
        end
      endcase
    end
  end

endmodule
